// File: rtl/hamming_encode_tx.sv
// rtl/hamming_encode_tx.sv - Hamming SEC encoder with optional single-bit error injection.
// Double-buffered serializer: one holding register feeds a shift register, position 1 first.
module hamming_encode_tx #(
  parameter int IP_BIT = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IP_BIT-1:0] in_data,
  input  logic              in_err_en,
  input  logic [3:0]        in_err_pos,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  localparam int         N    = IP_BIT + 4;
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic [4:0] N5   = 5'(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // Positions covered by parity bit k, laid out MSB = position 1.
  function automatic logic [N-1:0] cover_mask(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= N; p++) m = {m[N-2:0], ((p & k) != 0)};
    return m;
  endfunction

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_n;
  logic [N-1:0]   shreg, shreg_n;
  logic [N-1:0]   hold_buf, hold_n;
  logic [N-1:0]   data_map, codeword;
  logic [3:0]     cnt, cnt_n;
  logic           buf_full, full_n;
  logic           accept, load, flip;
  logic [IP_BIT-1:0] d_sh;

  always_comb begin
    d_sh     = in_data;
    data_map = '0;
    // Data fills non-power-of-two positions, MSB of the word first.
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) == 0) begin
        data_map = {data_map[N-2:0], 1'b0};
      end else begin
        data_map = {data_map[N-2:0], d_sh[IP_BIT-1]};
        d_sh     = {d_sh[IP_BIT-2:0], 1'b0};
      end
    end
    codeword = data_map;
    for (int k = 1; k < N; k = k * 2)
      codeword = codeword | ({{(N-1){1'b0}}, ^(data_map & cover_mask(k))} << (N - k));
    flip = in_err_en && (in_err_pos != 4'd0) && ({1'b0, in_err_pos} <= N5);
    if (flip) codeword = codeword ^ (ONE << (N5 - {1'b0, in_err_pos}));
  end

  assign in_ready  = !buf_full;
  assign accept    = in_valid && !buf_full;
  assign out_valid = (state == SHIFT);
  assign out_bit   = out_valid & shreg[N-1];
  assign out_last  = out_valid && (cnt == LAST);

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    hold_n  = hold_buf;
    full_n  = buf_full;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) load = 1'b1;
      end
      SHIFT: begin
        if (out_ready) begin
          if (cnt != LAST) begin
            shreg_n = {shreg[N-2:0], 1'b0};
            cnt_n   = cnt + 4'd1;
          end else if (buf_full) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Load and accept are exclusive: load needs buf_full, accept needs it clear.
    if (load) begin
      shreg_n = hold_buf;
      cnt_n   = 4'd0;
      full_n  = 1'b0;
      state_n = SHIFT;
    end
    if (accept) begin
      hold_n = codeword;
      full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= 4'd0;
      hold_buf <= '0;
      buf_full <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      cnt      <= cnt_n;
      hold_buf <= hold_n;
      buf_full <= full_n;
    end
  end

endmodule
